// File: rtl/snes_video_pattern_gen_if.sv
// SNES-side capture bus: pattern controls into the generator, dot-rate video out of it.
// The generator drives the master modport, the capture path sits on the slave modport.
interface snes_video_if;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;
    logic        dot_clock;
    logic        input_valid;
    logic        hsync;
    logic        vblank;
    logic        frame_start;
    logic [7:0]  R_out;
    logic [7:0]  G_out;
    logic [7:0]  B_out;

    modport master (
        input  mode, solid_rgb,
        output dot_clock, input_valid, hsync, vblank, frame_start, R_out, G_out, B_out
    );

    modport slave (
        output mode, solid_rgb,
        input  dot_clock, input_valid, hsync, vblank, frame_start, R_out, G_out, B_out
    );
endinterface

// File: rtl/snes_video_pattern_gen.sv
// Test-pattern video source emulating the PPU capture interface.
// Outputs change half a dot period after each dot_clock rising edge, so they are stable at that edge.
module snes_video_pattern_gen #(
    parameter int DOT_DIV     = 4,
    parameter int HTOTAL      = 341,
    parameter int HACTIVE     = 256,
    parameter int HSYNC_START = 277,
    parameter int HSYNC_LEN   = 25,
    parameter int VTOTAL      = 262,
    parameter int VACTIVE     = 224
) (
    input  logic            clk,
    input  logic            reset,
    snes_video_if.master    vid
);

    localparam int             PW         = $clog2(DOT_DIV);
    localparam logic [PW-1:0]  PHASE_LAST = PW'(DOT_DIV - 1);
    localparam logic [PW-1:0]  PHASE_ADV  = PW'(DOT_DIV / 2);
    localparam logic [8:0]     H_LAST     = 9'(HTOTAL - 1);
    localparam logic [8:0]     V_LAST     = 9'(VTOTAL - 1);
    localparam logic [8:0]     H_ACT      = 9'(HACTIVE);
    localparam logic [8:0]     V_ACT      = 9'(VACTIVE);
    localparam logic [8:0]     HS_BEGIN   = 9'(HSYNC_START);
    localparam logic [8:0]     HS_END     = 9'(HSYNC_START + HSYNC_LEN);

    logic [PW-1:0] phase_r;
    logic [8:0]    hcount_r;
    logic [8:0]    vcount_r;
    logic [1:0]    mode_r;
    logic [7:0]    frame_ctr_r;
    logic          first_frame_r;

    logic          advance_s;
    logic [8:0]    h_next_s;
    logic [8:0]    v_next_s;
    logic          frame_begin_s;
    logic          active_s;
    logic          hsync_s;
    logic          vblank_s;
    logic [1:0]    mode_eff_s;
    logic [7:0]    ctr_eff_s;
    logic [23:0]   pattern_s;
    logic [23:0]   rgb_s;

    // Raster position the next advance will issue.
    always_comb begin
        advance_s = (phase_r == PHASE_ADV);
        v_next_s  = vcount_r;
        if (hcount_r == H_LAST) begin
            h_next_s = 9'd0;
            if (vcount_r == V_LAST) begin
                v_next_s = 9'd0;
            end else begin
                v_next_s = vcount_r + 9'd1;
            end
        end else begin
            h_next_s = hcount_r + 9'd1;
        end
    end

    // Frame-level controls: the dot at (0,0) already belongs to the new frame's mode and count.
    always_comb begin
        frame_begin_s = (h_next_s == 9'd0) && (v_next_s == 9'd0);
        if (frame_begin_s) begin
            mode_eff_s = vid.mode;
        end else begin
            mode_eff_s = mode_r;
        end
        // The frame issued straight out of reset keeps count 0.
        if (frame_begin_s && !first_frame_r) begin
            ctr_eff_s = frame_ctr_r + 8'd1;
        end else begin
            ctr_eff_s = frame_ctr_r;
        end
    end

    // Timing flags and pixel colour for the next dot.
    always_comb begin
        active_s = (h_next_s < H_ACT) && (v_next_s < V_ACT);
        hsync_s  = (h_next_s >= HS_BEGIN) && (h_next_s < HS_END);
        vblank_s = (v_next_s >= V_ACT);
        case (mode_eff_s)
            2'd0:    pattern_s = {{8{h_next_s[7]}}, {8{h_next_s[6]}}, {8{h_next_s[5]}}};
            2'd1:    pattern_s = ((h_next_s[3:0] == 4'd0) || (v_next_s[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;
            2'd2:    pattern_s = {h_next_s[7:0], v_next_s[7:0], ctr_eff_s};
            2'd3:    pattern_s = vid.solid_rgb;
            default: pattern_s = 24'h000000;
        endcase
        if (active_s) begin
            rgb_s = pattern_s;
        end else begin
            rgb_s = 24'h000000;
        end
    end

    // Dot phase, raster counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r          <= {PW{1'b0}};
            hcount_r         <= H_LAST;
            vcount_r         <= V_LAST;
            mode_r           <= 2'd0;
            frame_ctr_r      <= 8'd0;
            first_frame_r    <= 1'b1;
            vid.dot_clock    <= 1'b0;
            vid.input_valid  <= 1'b0;
            vid.hsync        <= 1'b0;
            vid.vblank       <= 1'b0;
            vid.frame_start  <= 1'b0;
            vid.R_out        <= 8'd0;
            vid.G_out        <= 8'd0;
            vid.B_out        <= 8'd0;
        end else begin
            phase_r         <= (phase_r == PHASE_LAST) ? {PW{1'b0}} : phase_r + PW'(1);
            vid.dot_clock   <= (phase_r < PHASE_ADV);
            vid.frame_start <= advance_s && frame_begin_s;
            if (advance_s) begin
                hcount_r        <= h_next_s;
                vcount_r        <= v_next_s;
                vid.input_valid <= active_s;
                vid.hsync       <= hsync_s;
                vid.vblank      <= vblank_s;
                vid.R_out       <= rgb_s[23:16];
                vid.G_out       <= rgb_s[15:8];
                vid.B_out       <= rgb_s[7:0];
                if (frame_begin_s) begin
                    mode_r        <= mode_eff_s;
                    frame_ctr_r   <= ctr_eff_s;
                    first_frame_r <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_snes_video_pattern_gen.sv
// Scoreboarded bench: two generators with shortened frames, expected dots queued per instance.
module tb_snes_video_pattern_gen;

    typedef struct {
        int          n;
        logic [23:0] rgb;
        logic        iv;
        logic        hs;
        logic        vb;
    } exp_t;

    typedef struct {
        logic        dc;
        logic        iv;
        logic        hs;
        logic        vb;
        logic        fs;
        logic [23:0] rgb;
    } samp_t;

    localparam int H      = 341;
    localparam int FR [2] = '{341 * 12, 341 * 36};
    localparam int DD [2] = '{4, 2};

    logic clk;
    logic rst0;
    logic rst1;
    int   n_vec;
    int   n_bad;
    int   clk_cnt;
    int   cyc0;
    logic rq [2];
    exp_t q0 [$];
    exp_t q1 [$];

    snes_video_if v0 ();
    snes_video_if v1 ();

    snes_video_pattern_gen #(
        .DOT_DIV(4), .HTOTAL(341), .HACTIVE(256), .HSYNC_START(277), .HSYNC_LEN(25),
        .VTOTAL(12), .VACTIVE(8)
    ) dut (
        .clk(clk), .reset(rst0), .vid(v0)
    );

    snes_video_pattern_gen #(
        .DOT_DIV(2), .HTOTAL(341), .HACTIVE(256), .HSYNC_START(277), .HSYNC_LEN(25),
        .VTOTAL(36), .VACTIVE(34)
    ) dut_grid (
        .clk(clk), .reset(rst1), .vid(v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input int ch, input int n, input logic [23:0] rgb,
                                 input logic iv, input logic hs, input logic vb);
        exp_t e;
        e = '{n, rgb, iv, hs, vb};
        if (ch == 0) q0.push_back(e);
        else         q1.push_back(e);
    endfunction

    function automatic int qsize(input int ch);
        return (ch == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(input int ch);
        return (ch == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpop(input int ch);
        if (ch == 0) void'(q0.pop_front());
        else         void'(q1.pop_front());
    endfunction

    // Reset sampling and cycle counters, updated on the active edge.
    initial begin
        clk_cnt = 0;
        cyc0    = 0;
        rq[0]   = 1'b0;
        rq[1]   = 1'b0;
        forever begin
            @(posedge clk);
            clk_cnt++;
            rq[0] = rst0;
            rq[1] = rst1;
            if (rst0) cyc0 = 0;
            else      cyc0++;
        end
    end

    // Monitor: on each dot_clock rise, pop and compare the expected dot with the same index.
    initial begin : monitor
        int    rc [2];
        int    last_rise [2];
        int    fs_rc [2];
        int    ivc [2];
        logic  prev_dc [2];
        logic  prev_fs [2];
        samp_t s;
        exp_t  e;
        int    dot;
        bit    ok;
        for (int i = 0; i < 2; i++) begin
            rc[i] = 0; last_rise[i] = 0; fs_rc[i] = -1; ivc[i] = 0;
            prev_dc[i] = 1'b0; prev_fs[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < 2; ch++) begin
                if (ch == 0) s = '{v0.dot_clock, v0.input_valid, v0.hsync, v0.vblank, v0.frame_start, {v0.R_out, v0.G_out, v0.B_out}};
                else         s = '{v1.dot_clock, v1.input_valid, v1.hsync, v1.vblank, v1.frame_start, {v1.R_out, v1.G_out, v1.B_out}};
                if (rq[ch]) begin
                    n_vec++;
                    if ({s.dc, s.iv, s.hs, s.vb, s.fs, s.rgb} !== 29'd0) begin
                        n_bad++;
                        $display("FAIL reset_outputs ch%0d: got dc=%b iv=%b hs=%b vb=%b fs=%b rgb=%06h, expected all zero",
                                 ch, s.dc, s.iv, s.hs, s.vb, s.fs, s.rgb);
                    end
                    rc[ch] = 0; fs_rc[ch] = -1; ivc[ch] = 0;
                    prev_dc[ch] = 1'b0; prev_fs[ch] = 1'b0;
                end else begin
                    if (s.fs === 1'b1) begin
                        n_vec++;
                        ok = (rc[ch] >= 1) && ((rc[ch] - 1) % FR[ch] == 0) && (prev_fs[ch] === 1'b0)
                             && (s.vb === 1'b0) && (s.iv === 1'b1);
                        if (!ok) begin
                            n_bad++;
                            $display("FAIL frame_start_pulse ch%0d: pulse at rise %0d prev=%b vb=%b iv=%b, expected single pulse at rise 1 mod %0d with vb=0 iv=1",
                                     ch, rc[ch], prev_fs[ch], s.vb, s.iv, FR[ch]);
                        end
                        fs_rc[ch] = rc[ch];
                    end
                    if (s.dc === 1'b1 && prev_dc[ch] === 1'b0) begin
                        rc[ch]++;
                        if (rc[ch] >= 2) begin
                            n_vec++;
                            if (clk_cnt - last_rise[ch] != DD[ch]) begin
                                n_bad++;
                                $display("FAIL dot_period ch%0d: got %0d clks, expected %0d", ch, clk_cnt - last_rise[ch], DD[ch]);
                            end
                        end
                        last_rise[ch] = clk_cnt;
                        dot = rc[ch] - 2;
                        if (dot >= 0) begin
                            if (dot % FR[ch] == 0) begin
                                n_vec++;
                                if (fs_rc[ch] != dot + 1) begin
                                    n_bad++;
                                    $display("FAIL frame_start_seen ch%0d dot=%0d: last pulse at rise %0d, expected %0d", ch, dot, fs_rc[ch], dot + 1);
                                end
                            end
                            if (dot % FR[ch] < H) begin
                                if (dot % FR[ch] == 0) ivc[ch] = 0;
                                ivc[ch] += int'(s.iv === 1'b1);
                                if (dot % FR[ch] == H - 1) begin
                                    n_vec++;
                                    if (ivc[ch] != 256) begin
                                        n_bad++;
                                        $display("FAIL line0_valid_count ch%0d: got %0d, expected 256", ch, ivc[ch]);
                                    end
                                end
                            end
                            while (qsize(ch) > 0) begin
                                e = qfront(ch);
                                if (e.n > dot) break;
                                qpop(ch);
                                n_vec++;
                                if (e.n != dot) begin
                                    n_bad++;
                                    $display("FAIL dot_skipped ch%0d: expected dot %0d never presented (now %0d)", ch, e.n, dot);
                                end else if (s.rgb !== e.rgb || s.iv !== e.iv || s.hs !== e.hs || s.vb !== e.vb) begin
                                    n_bad++;
                                    $display("FAIL dot ch%0d n=%0d: got rgb=%06h iv=%b hs=%b vb=%b, expected rgb=%06h iv=%b hs=%b vb=%b",
                                             ch, dot, s.rgb, s.iv, s.hs, s.vb, e.rgb, e.iv, e.hs, e.vb);
                                end
                            end
                        end
                    end
                    prev_dc[ch] = s.dc;
                    prev_fs[ch] = s.fs;
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc0 < c) @(negedge clk);
    endtask

    // Stimulus: directed raster points with hand-computed colours.
    initial begin
        n_vec = 0;
        n_bad = 0;
        rst0 = 1'b1;
        rst1 = 1'b1;
        v0.mode = 2'd0;
        v0.solid_rgb = 24'hABCDEF;
        v1.mode = 2'd1;
        v1.solid_rgb = 24'h123456;

        // Instance 0: 341x12 frame, 8 active lines, colour bars then gradient.
        push(0, 0,         24'h000000, 1'b1, 1'b0, 1'b0);
        push(0, 32,        24'h0000FF, 1'b1, 1'b0, 1'b0);
        push(0, 160,       24'hFF00FF, 1'b1, 1'b0, 1'b0);
        push(0, 255,       24'hFFFFFF, 1'b1, 1'b0, 1'b0);
        push(0, 256,       24'h000000, 1'b0, 1'b0, 1'b0);
        push(0, 276,       24'h000000, 1'b0, 1'b0, 1'b0);
        push(0, 277,       24'h000000, 1'b0, 1'b1, 1'b0);
        push(0, 301,       24'h000000, 1'b0, 1'b1, 1'b0);
        push(0, 302,       24'h000000, 1'b0, 1'b0, 1'b0);
        push(0, 6*H+100,   24'h00FFFF, 1'b1, 1'b0, 1'b0);
        push(0, 7*H+340,   24'h000000, 1'b0, 1'b0, 1'b0);
        push(0, 8*H,       24'h000000, 1'b0, 1'b0, 1'b1);
        push(0, 8*H+280,   24'h000000, 1'b0, 1'b1, 1'b1);
        push(0, 4091,      24'h000000, 1'b0, 1'b0, 1'b1);
        push(0, 4092,      24'h000001, 1'b1, 1'b0, 1'b0);
        push(0, 4092+7*H+5, 24'h050701, 1'b1, 1'b0, 1'b0);
        push(0, 8184+7*H+5, 24'h050702, 1'b1, 1'b0, 1'b0);

        // Instance 1: 341x36 frame, 34 active lines, grid then solid colour.
        push(1, 3*H+16,       24'hFFFFFF, 1'b1, 1'b0, 1'b0);
        push(1, 3*H+17,       24'h000000, 1'b1, 1'b0, 1'b0);
        push(1, 32*H+17,      24'hFFFFFF, 1'b1, 1'b0, 1'b0);
        push(1, 12276+2*H+10, 24'h123456, 1'b1, 1'b0, 1'b0);
        push(1, 12276+34*H+3, 24'h000000, 1'b0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;

        wait_cyc(10);
        v1.mode = 2'd3;
        // Start of line 5 of the first frame: only the next frame may switch to gradient.
        wait_cyc(4 * 5 * H + 3);
        v0.mode = 2'd2;
        // Dot 150 of line 7 in the third frame is on screen; pulse reset for one clk.
        wait_cyc(4 * (8184 + 7*H + 150) + 4);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        push(0, 0,       24'h000000, 1'b1, 1'b0, 1'b0);
        push(0, 277,     24'h000000, 1'b0, 1'b1, 1'b0);
        push(0, 7*H+5,   24'h050700, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 20000 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
        n_vec++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
